// File: rtl/axi_stream_transmitter.sv
// AXI4-Stream master: 2-entry skid buffer (head + skid) framing packets with TLAST from in_last or after MAX_BEATS beats.
// Latency: 1 cycle from push to TVALID. Backpressure: in_ready drops at 2 buffered beats or while the TLAST beat waits.
module axi_stream_transmitter #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_BEATS  = 17
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_keep,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_WIDTH-1:0]     tx_id,
  input  logic                    tx_dest,
  output logic [DATA_WIDTH-1:0]   TDATA,
  output logic                    TVALID,
  input  logic                    TREADY,
  output logic                    TLAST,
  output logic [DATA_WIDTH/8-1:0] TKEEP,
  output logic [DATA_WIDTH/8-1:0] TSTRB,
  output logic [ID_WIDTH-1:0]     TID,
  output logic                    TDEST,
  output logic [2:0]              TUSER,
  output logic [15:0]             pkt_count,
  output logic                    busy
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, LAST_WAIT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
    logic [2:0]            user;
    logic [ID_WIDTH-1:0]   id;
    logic                  dest;
  } beat_t;

  function automatic logic [3:0] popcnt(input logic [KW-1:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < KW; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  state_t              state, state_n;
  beat_t               head_q, skid_q, new_beat;
  logic [1:0]          cnt_q, cnt_n;
  logic [BW-1:0]       bcnt_q;
  logic [ID_WIDTH-1:0] pkt_id_q;
  logic                pkt_dest_q;
  logic                in_ready_q;
  logic                push, pop, new_last;
  logic [3:0]          keep_pc;

  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = (cnt_q != 2'd0) && TREADY;
    new_last = in_last || (bcnt_q == BMAX);
    keep_pc  = popcnt(in_keep);

    // id/dest come straight from the port on the opening beat, then from the packet latch
    new_beat.data = in_data;
    new_beat.keep = in_keep;
    new_beat.last = new_last;
    new_beat.user = keep_pc[2:0];
    new_beat.id   = (state == IDLE) ? tx_id : pkt_id_q;
    new_beat.dest = (state == IDLE) ? tx_dest : pkt_dest_q;

    cnt_n = cnt_q;
    if (push && !pop)      cnt_n = cnt_q + 2'd1;
    else if (!push && pop) cnt_n = cnt_q - 2'd1;

    state_n = state;
    case (state)
      IDLE:      if (push) state_n = new_last ? LAST_WAIT : STREAM;
      STREAM:    if (push && new_last) state_n = LAST_WAIT;
      LAST_WAIT: if (pop && head_q.last) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      head_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= 2'd0;
      bcnt_q     <= '0;
      pkt_id_q   <= '0;
      pkt_dest_q <= 1'b0;
      in_ready_q <= 1'b0;
      pkt_count  <= 16'd0;
    end else begin
      state      <= state_n;
      cnt_q      <= cnt_n;
      in_ready_q <= (cnt_n != 2'd2) && (state_n != LAST_WAIT);

      if (push) begin
        bcnt_q <= new_last ? '0 : bcnt_q + BW'(1);
        if (state == IDLE) begin
          pkt_id_q   <= tx_id;
          pkt_dest_q <= tx_dest;
        end
      end

      if (state == LAST_WAIT && pop && head_q.last)
        pkt_count <= pkt_count + 16'd1;

      // Push at count 2 cannot happen, so the skid only ever refills the head on pop
      if (pop) begin
        if (cnt_q == 2'd2)  head_q <= skid_q;
        else if (push)      head_q <= new_beat;
      end else if (push) begin
        if (cnt_q == 2'd0)  head_q <= new_beat;
        else                skid_q <= new_beat;
      end
    end
  end

  assign in_ready = in_ready_q;
  assign TVALID   = (cnt_q != 2'd0);
  assign TDATA    = head_q.data;
  assign TLAST    = head_q.last;
  assign TKEEP    = head_q.keep;
  assign TSTRB    = head_q.keep;
  assign TUSER    = head_q.user;
  assign TID      = head_q.id;
  assign TDEST    = head_q.dest;
  assign busy     = (state != IDLE) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_axi_stream_transmitter.sv
// Directed bench for axi_stream_transmitter with hand-computed expectations.
module tb_axi_stream_transmitter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last, in_valid, in_ready;
  logic [7:0]  tx_id;
  logic        tx_dest;
  logic [63:0] TDATA;
  logic        TVALID, TREADY, TLAST;
  logic [7:0]  TKEEP, TSTRB, TID;
  logic        TDEST;
  logic [2:0]  TUSER;
  logic [15:0] pkt_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_stream_transmitter #(.DATA_WIDTH(64), .ID_WIDTH(8), .MAX_BEATS(17)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .tx_id(tx_id), .tx_dest(tx_dest),
    .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST),
    .TKEEP(TKEEP), .TSTRB(TSTRB), .TID(TID), .TDEST(TDEST), .TUSER(TUSER),
    .pkt_count(pkt_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn = 1'b0; in_data = '0; in_keep = 8'hFF; in_last = 1'b0; in_valid = 1'b0;
    tx_id = 8'h33; tx_dest = 1'b1; TREADY = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_tvalid", TVALID, 0);
    chk("rst_tlast", TLAST, 0);
    chk("rst_tdata", TDATA, 0);
    chk("rst_tuser", TUSER, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_inrdy", in_ready, 0);
    chk("rst_busy", busy, 0);
    ARESETn = 1'b1;
    tick;
    chk("rst_inrdy_rise", in_ready, 1);

    // Three-beat packet at full throughput
    TREADY = 1'b1; in_valid = 1'b1; in_data = 64'hA1;
    tick;
    chk("p1_a1", TDATA, 64'hA1);
    chk("p1_a1_last", TLAST, 0);
    chk("p1_tid", TID, 8'h33);
    chk("p1_tdest", TDEST, 1);
    in_data = 64'hA2;
    tick;
    chk("p1_a2", TDATA, 64'hA2);
    chk("p1_a2_vld", TVALID, 1);
    in_data = 64'hA3; in_last = 1'b1;
    tick;
    chk("p1_a3", TDATA, 64'hA3);
    chk("p1_a3_last", TLAST, 1);
    chk("p1_inrdy_lw", in_ready, 0);
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("p1_done_vld", TVALID, 0);
    chk("p1_pkt", pkt_count, 1);
    chk("p1_busy", busy, 0);
    chk("p1_inrdy", in_ready, 1);

    // 17 beats without in_last: TLAST forced on beat 17
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 64'h100 + 64'(i);
      tick;
      chk("p2_data", TDATA, 64'h100 + 64'(i));
      chk("p2_last", TLAST, (i == 16) ? 64'd1 : 64'd0);
    end
    chk("p2_inrdy_blk", in_ready, 0);
    in_data = 64'h999;
    tick;
    chk("p2_drain_vld", TVALID, 0);
    chk("p2_pkt", pkt_count, 2);
    chk("p2_inrdy", in_ready, 1);
    tick;
    chk("p2_new_data", TDATA, 64'h999);
    chk("p2_new_nolast", TLAST, 0);
    in_data = 64'h99A; in_last = 1'b1;
    tick;
    chk("p2_new2_data", TDATA, 64'h99A);
    chk("p2_new2_last", TLAST, 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("p2_pkt3", pkt_count, 3);

    // Backpressure, partial keep, id held for the packet
    TREADY = 1'b0; tx_id = 8'h5A; in_valid = 1'b1; in_data = 64'hB1;
    tick;
    chk("p3_b1", TDATA, 64'hB1);
    chk("p3_tid", TID, 8'h5A);
    chk("p3_busy", busy, 1);
    tx_id = 8'h11; in_data = 64'hB2;
    tick;
    chk("p3_inrdy_full", in_ready, 0);
    chk("p3_hold_b1", TDATA, 64'hB1);
    in_data = 64'hB3; in_keep = 8'h07; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("p3_stall_data", TDATA, 64'hB1);
      chk("p3_stall_last", TLAST, 0);
      chk("p3_stall_rdy", in_ready, 0);
    end
    TREADY = 1'b1;
    tick;
    chk("p3_b2", TDATA, 64'hB2);
    chk("p3_b2_tid", TID, 8'h5A);
    chk("p3_inrdy_back", in_ready, 1);
    tick;
    chk("p3_b3", TDATA, 64'hB3);
    chk("p3_b3_last", TLAST, 1);
    chk("p3_tkeep", TKEEP, 8'h07);
    chk("p3_tstrb", TSTRB, 8'h07);
    chk("p3_tuser", TUSER, 3);
    chk("p3_b3_tid", TID, 8'h5A);
    in_valid = 1'b0;
    tick;
    chk("p3_drained", TVALID, 0);
    chk("p3_pkt", pkt_count, 4);

    // Next packet picks up the new id; full keep gives TUSER 0
    in_valid = 1'b1; in_data = 64'hC1; in_keep = 8'hFF; in_last = 1'b1;
    tick;
    chk("p4_tid", TID, 8'h11);
    chk("p4_tuser", TUSER, 0);
    chk("p4_last", TLAST, 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("p4_pkt", pkt_count, 5);

    // Reset with two beats buffered mid-packet
    TREADY = 1'b0; in_valid = 1'b1; in_data = 64'hD1;
    tick;
    in_data = 64'hD2;
    tick;
    chk("p5_full", in_ready, 0);
    in_valid = 1'b0;
    #2 ARESETn = 1'b0;
    #1;
    chk("p5_rst_vld", TVALID, 0);
    chk("p5_rst_pkt", pkt_count, 0);
    chk("p5_rst_busy", busy, 0);
    chk("p5_rst_data", TDATA, 0);
    #2 ARESETn = 1'b1;
    tick;
    chk("p5_inrdy", in_ready, 1);
    TREADY = 1'b1; tx_id = 8'h77; in_valid = 1'b1; in_data = 64'hE1; in_last = 1'b1;
    tick;
    chk("p5_e1", TDATA, 64'hE1);
    chk("p5_e1_last", TLAST, 1);
    chk("p5_e1_tid", TID, 8'h77);
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("p5_pkt", pkt_count, 1);
    chk("p5_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
